// File: rtl/rc4_pkg.sv
// Shared definitions between the key search sequencer and the RC4 RAM controller:
// sequencer states, RAM controller phase encodings and finish_bus bit positions.
package rc4_pkg;

  localparam int unsigned MODE_W  = 6;
  localparam int unsigned STATE_W = 4;

  localparam logic [MODE_W-1:0] MODE_IDLE    = 6'b000_000;
  localparam logic [MODE_W-1:0] MODE_INIT    = 6'b001_000;
  localparam logic [MODE_W-1:0] MODE_SHUFFLE = 6'b010_000;
  localparam logic [MODE_W-1:0] MODE_DECRYPT = 6'b011_000;

  localparam int unsigned FIN_INIT    = 0;
  localparam int unsigned FIN_SHUFFLE = 1;
  localparam int unsigned FIN_DECRYPT = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_INIT,
    S_GAP1,
    S_SHUFFLE,
    S_GAP2,
    S_DECRYPT,
    S_EVAL,
    S_NEXT,
    S_FOUND,
    S_EXHAUST,
    S_TIMEOUT
  } state_e;

  // Phase select presented to the RAM controller for a given sequencer state.
  function automatic logic [MODE_W-1:0] mode_of(input state_e s);
    case (s)
      S_INIT:    return MODE_INIT;
      S_SHUFFLE: return MODE_SHUFFLE;
      S_DECRYPT: return MODE_DECRYPT;
      default:   return MODE_IDLE;
    endcase
  endfunction

  function automatic logic is_phase(input state_e s);
    return (s == S_INIT) || (s == S_SHUFFLE) || (s == S_DECRYPT);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags a RAM controller phase that never reports done.
// Only instantiated when KEYSEQ_WATCHDOG_EN is defined.
module phase_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_phase,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYCLES-th cycle spent in the current phase.
  assign expired_c = in_phase && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (in_phase && !expired_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_search_sequencer.sv
// Brute-force RC4 key search: steps candidate keys through the RAM controller's
// init/shuffle/decrypt phases. Optional watchdog enabled by KEYSEQ_WATCHDOG_EN.
module key_search_sequencer
  import rc4_pkg::*;
#(
  parameter int unsigned RAM_WIDTH      = 8,
  parameter int unsigned KEY_LENGTH     = 3,
  parameter int unsigned KEY_BITS       = 22,
  parameter int unsigned NUM_DEVICES    = 3,
  parameter int unsigned KEY_START      = 0,
  parameter int unsigned KEY_STEP       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_DEVICES-1:0]           finish_bus,
  input  logic                             success,
  output logic [MODE_W-1:0]                mode,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
  output logic                             busy,
  output logic                             found,
  output logic                             exhausted,
  output logic                             timeout
);

  localparam int unsigned KEY_W = KEY_LENGTH * RAM_WIDTH;
  localparam int unsigned SUM_W = KEY_BITS + 1;

  state_e              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic                success_q, success_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                found_q, found_d;
  logic                exhausted_q, exhausted_d;
  logic                timeout_d;
  logic [SUM_W-1:0]    key_sum_c;
  logic                key_over_c;
  logic                wd_expired_c;

  // One extra bit so stepping past the top of the key space is visible.
  assign key_sum_c  = SUM_W'(key_q) + SUM_W'(KEY_STEP);
  assign key_over_c = key_sum_c[KEY_BITS];

`ifdef KEYSEQ_WATCHDOG_EN
  logic timeout_q;

  phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_phase_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    ((state_d != state_q) && is_phase(state_d)),
    .in_phase (is_phase(state_q)),
    .expired_c(wd_expired_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Limit is meaningless without the watchdog; the term keeps the parameter referenced.
  assign wd_expired_c = 1'b0 && (TIMEOUT_CYCLES != 0);
  assign timeout      = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_q       <= KEY_BITS'(KEY_START);
      success_q   <= 1'b0;
      mode_q      <= MODE_IDLE;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      success_q   <= success_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      found_q     <= found_d;
      exhausted_q <= exhausted_d;
    end
  end

  // Next-state logic; each phase only listens to its own finish bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_INIT;
      S_INIT: begin
        if (finish_bus[FIN_INIT])         state_d = S_GAP1;
        else if (wd_expired_c)            state_d = S_TIMEOUT;
      end
      S_GAP1:    state_d = S_SHUFFLE;
      S_SHUFFLE: begin
        if (finish_bus[FIN_SHUFFLE])      state_d = S_GAP2;
        else if (wd_expired_c)            state_d = S_TIMEOUT;
      end
      S_GAP2:    state_d = S_DECRYPT;
      S_DECRYPT: begin
        if (finish_bus[FIN_DECRYPT])      state_d = S_EVAL;
        else if (wd_expired_c)            state_d = S_TIMEOUT;
      end
      S_EVAL: begin
        if (success_q)                    state_d = S_FOUND;
        else if (key_over_c)              state_d = S_EXHAUST;
        else                              state_d = S_NEXT;
      end
      S_NEXT:    state_d = S_INIT;
      default:   state_d = state_q;
    endcase
  end

  // Output and datapath updates, registered from the upcoming state.
  always_comb begin
    key_d       = key_q;
    success_d   = success_q;
    mode_d      = mode_of(state_d);
    busy_d      = !(state_d inside {S_IDLE, S_FOUND, S_EXHAUST, S_TIMEOUT});
    found_d     = (state_d == S_FOUND);
    exhausted_d = (state_d == S_EXHAUST);
    timeout_d   = (state_d == S_TIMEOUT);
    if ((state_q == S_IDLE) && (state_d == S_INIT)) begin
      key_d = KEY_BITS'(KEY_START);
    end
    if (state_q == S_NEXT) begin
      key_d = key_sum_c[KEY_BITS-1:0];
    end
    if ((state_q == S_DECRYPT) && finish_bus[FIN_DECRYPT]) begin
      success_d = success;
    end
  end

  assign mode      = mode_q;
  assign key       = KEY_W'(key_q);
  assign busy      = busy_q;
  assign found     = found_q;
  assign exhausted = exhausted_q;

endmodule

// File: tb/tb_key_search_sequencer.sv
// Self-checking bench for key_search_sequencer: a per-cycle schedule model of each
// search plus literal checks; the watchdog scenario runs when KEYSEQ_WATCHDOG_EN is set.
module tb_key_search_sequencer;

  localparam int unsigned KB       = 22;
  localparam int unsigned KW       = 24;
  localparam int unsigned EX_START = (1 << KB) - 2;

  typedef struct {
    logic [5:0]  mode;
    logic [23:0] key;
    logic        busy;
    logic        found;
    logic        exh;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic [2:0] finish_bus;
  logic success;

  logic [5:0]    mode0, mode1;
  logic [KW-1:0] key0, key1;
  logic busy0, found0, exh0, to0;
  logic busy1, found1, exh1, to1;

  int sel;
  logic [5:0]    o_mode;
  logic [KW-1:0] o_key;
  logic o_busy, o_found, o_exh, o_to;

  int n_cmp = 0;
  int n_bad = 0;
  int inits;
  logic [5:0] trace [5];

  exp_t       exp_q [$];
  logic [2:0] fin_q [$];
  logic       suc_q [$];

  always #5 clk = ~clk;

  key_search_sequencer #(.TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .finish_bus(finish_bus), .success(success),
    .mode(mode0), .key(key0), .busy(busy0), .found(found0), .exhausted(exh0), .timeout(to0)
  );

  key_search_sequencer #(.KEY_START(EX_START), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .finish_bus(finish_bus), .success(success),
    .mode(mode1), .key(key1), .busy(busy1), .found(found1), .exhausted(exh1), .timeout(to1)
  );

  always_comb begin
    if (sel == 0) begin
      o_mode = mode0; o_key = key0; o_busy = busy0; o_found = found0; o_exh = exh0; o_to = to0;
    end else begin
      o_mode = mode1; o_key = key1; o_busy = busy1; o_found = found1; o_exh = exh1; o_to = to1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic [5:0] m, input longint k, input bit b, input bit f,
                      input bit e, input logic [2:0] fin, input bit s);
    exp_t x;
    x.mode = m; x.key = 24'(k); x.busy = b; x.found = f; x.exh = e;
    exp_q.push_back(x);
    fin_q.push_back(fin);
    suc_q.push_back(s);
  endtask

  // Expected per-cycle behaviour of one whole search, with the finish/success stimulus.
  task automatic build(input longint kstart, input int max_d, input int succ_at);
    longint k = kstart;
    int c = 0;
    bit fnd = 0;
    logic [5:0] pmode [3];
    pmode[0] = 6'b001000; pmode[1] = 6'b010000; pmode[2] = 6'b011000;
    exp_q.delete(); fin_q.delete(); suc_q.delete();
    forever begin
      bit ok = (c == succ_at);
      for (int p = 0; p < 3; p++) begin
        int d = $urandom_range(max_d, 0);
        for (int i = 0; i <= d; i++) begin
          logic [2:0] f = 3'($urandom);
          f[p] = (i == d);
          push(pmode[p], k, 1, 0, 0, f, (p == 2 && i == d) ? ok : 1'($urandom));
        end
        if (p < 2) push(6'b0, k, 1, 0, 0, 3'($urandom), 1'($urandom));
      end
      push(6'b0, k, 1, 0, 0, 3'($urandom), 1'($urandom));
      if (ok) begin fnd = 1; break; end
      if (k + 1 > 64'h3FFFFF) break;
      push(6'b0, k, 1, 0, 0, 3'($urandom), 1'($urandom));
      k++;
      c++;
    end
    repeat (4) push(6'b0, k, 0, fnd, !fnd, 3'($urandom), 1'($urandom));
  endtask

  // Start the selected DUT and compare every cycle against the built schedule.
  task automatic run_sched(input int s);
    logic [5:0] prev = 6'b0;
    sel = s;
    inits = 0;
    @(negedge clk);
    if (s == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int n = 0; n < exp_q.size(); n++) begin
      chk($sformatf("mode[%0d]", n),  64'(o_mode),  64'(exp_q[n].mode));
      chk($sformatf("key[%0d]", n),   64'(o_key),   64'(exp_q[n].key));
      chk($sformatf("busy[%0d]", n),  64'(o_busy),  64'(exp_q[n].busy));
      chk($sformatf("found[%0d]", n), 64'(o_found), 64'(exp_q[n].found));
      chk($sformatf("exh[%0d]", n),   64'(o_exh),   64'(exp_q[n].exh));
      chk($sformatf("to[%0d]", n),    64'(o_to),    64'(0));
      if (o_mode == 6'b001000 && prev != 6'b001000) inits++;
      if (n < 5) trace[n] = o_mode;
      prev = o_mode;
      finish_bus = fin_q[n];
      success    = suc_q[n];
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; finish_bus = 3'b0; success = 1'b0; start0 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; finish_bus = 3'b0; success = 1'b0; sel = 0;
    @(negedge clk);
    chk("rst_mode0", 64'(mode0), 64'(0));
    chk("rst_key0",  64'(key0),  64'(0));
    chk("rst_busy0", 64'(busy0), 64'(0));
    chk("rst_found0", 64'(found0), 64'(0));
    chk("rst_exh0",  64'(exh0),  64'(0));
    chk("rst_to0",   64'(to0),   64'(0));
    chk("rst_key1",  64'(key1),  64'h3FFFFE);
    @(negedge clk);
    reset = 1'b0;

    // Happy path, all phases one cycle, success on the first key
    build(0, 0, 0);
    run_sched(0);
    chk("happy_m0", 64'(trace[0]), 64'h08);
    chk("happy_m1", 64'(trace[1]), 64'h00);
    chk("happy_m2", 64'(trace[2]), 64'h10);
    chk("happy_m3", 64'(trace[3]), 64'h00);
    chk("happy_m4", 64'(trace[4]), 64'h18);
    chk("happy_found", 64'(found0), 64'(1));
    chk("happy_key", 64'(key0), 64'(0));
    chk("happy_busy", 64'(busy0), 64'(0));

    // Iteration: keys 0..4 fail, key 5 succeeds
    do_reset();
    build(0, 4, 5);
    run_sched(0);
    chk("iter_inits", 64'(inits), 64'(6));
    chk("iter_key", 64'(key0), 64'h000005);
    chk("iter_found", 64'(found0), 64'(1));

    // Stray decrypt/shuffle finish during INIT is ignored
    do_reset();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("stray_m0", 64'(mode0), 64'h08);
    finish_bus = 3'b110; success = 1'b1;
    @(negedge clk);
    chk("stray_m1", 64'(mode0), 64'h08);
    chk("stray_busy", 64'(busy0), 64'(1));
    finish_bus = 3'b001;
    @(negedge clk);
    chk("stray_gap", 64'(mode0), 64'h00);
    finish_bus = 3'b000; success = 1'b0;

    // Mid-phase reset during SHUFFLE, then a normal restart
    do_reset();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    finish_bus = 3'b001;
    @(negedge clk); finish_bus = 3'b000;
    @(negedge clk);
    chk("mid_shuffle", 64'(mode0), 64'h10);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_mode", 64'(mode0), 64'(0));
    chk("mid_rst_key", 64'(key0), 64'(0));
    chk("mid_rst_busy", 64'(busy0), 64'(0));
    @(negedge clk); reset = 1'b0;
    build(0, 3, 1);
    run_sched(0);
    chk("mid_restart_found", 64'(found0), 64'(1));
    chk("mid_restart_key", 64'(key0), 64'(1));

    // Randomized searches
    for (int r = 0; r < 4; r++) begin
      int sa = $urandom_range(3, 0);
      do_reset();
      build(0, 5, sa);
      run_sched(0);
      chk("rnd_inits", 64'(inits), 64'(sa + 1));
    end

    // Exhaustion near the top of the key space
    do_reset();
    build(longint'(EX_START), 3, -1);
    run_sched(1);
    chk("exh_inits", 64'(inits), 64'(2));
    chk("exh_key", 64'(key1), 64'h3FFFFF);
    chk("exh_flag", 64'(exh1), 64'(1));
    chk("exh_found", 64'(found1), 64'(0));
    sel = 0;

`ifdef KEYSEQ_WATCHDOG_EN
    // No init finish: timeout after 16 cycles in INIT
    do_reset();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; finish_bus = 3'b000;
    for (int n = 0; n <= 16; n++) begin
      if (n == 15) begin
        chk("wd_pre_mode", 64'(mode0), 64'h08);
        chk("wd_pre_to", 64'(to0), 64'(0));
      end
      if (n == 16) begin
        chk("wd_to", 64'(to0), 64'(1));
        chk("wd_mode", 64'(mode0), 64'(0));
        chk("wd_busy", 64'(busy0), 64'(0));
      end
      @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_search_sequencer.md
KEY_SEARCH_SEQUENCER -- requirements
Module: key_search_sequencer

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, byte width of each key byte.
REQ-002 SHALL have parameter KEY_LENGTH, default 3, number of key bytes.
REQ-003 SHALL have parameter KEY_BITS, default 22, number of searched low-order key bits; all higher key bits are driven 0.
REQ-004 SHALL have parameter NUM_DEVICES, default 3, width of finish_bus.
REQ-005 SHALL have parameters KEY_START (default 0) and KEY_STEP (default 1), the first candidate key and the increment between candidates.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 4096, the per-phase watchdog limit.
REQ-007 SHALL have one clock and an asynchronous active-high reset: clk input 1, clock; reset input 1, asynchronous active-high reset.
REQ-008 SHALL have ports: start input 1, begin search (level, sampled in IDLE).
REQ-009 SHALL have ports: finish_bus input NUM_DEVICES, per-phase done flags from the RAM controller (bit0 init, bit1 shuffle, bit2 decrypt).
REQ-010 SHALL have ports: success input 1, decrypt plaintext-valid flag, sampled only with finish_bus[2].
REQ-011 SHALL have ports: mode output 6, phase select to the RAM controller.
REQ-012 SHALL have ports: key output KEY_LENGTH x RAM_WIDTH, packed candidate key, byte 0 in the most significant byte.
REQ-013 SHALL have ports: busy output 1; found output 1; exhausted output 1; timeout output 1.

Function
REQ-014 SHALL implement the states IDLE, INIT, GAP1, SHUFFLE, GAP2, DECRYPT, EVAL, NEXT, FOUND, EXHAUST and TIMEOUT.
REQ-015 SHALL drive mode from the state: 6'b001_000 in INIT, 6'b010_000 in SHUFFLE, 6'b011_000 in DECRYPT, 6'b000_000 in all other states.
REQ-016 SHALL transition IDLE->INIT when start=1, loading key=KEY_START and clearing found, exhausted and timeout.
REQ-017 SHALL transition INIT->GAP1 when finish_bus[0]=1, GAP1->SHUFFLE unconditionally, SHUFFLE->GAP2 when finish_bus[1]=1, GAP2->DECRYPT unconditionally, and DECRYPT->EVAL when finish_bus[2]=1.
REQ-018 SHALL force mode=0 for exactly one cycle in each GAP state so that the next sub-engine sees a fresh start edge.
REQ-019 SHALL ignore finish bits belonging to phases other than the current one.
REQ-020 SHALL register success in the cycle where finish_bus[2]=1 and state is DECRYPT.
REQ-021 SHALL leave EVAL to FOUND if the registered success=1; otherwise to EXHAUST if key+KEY_STEP exceeds 2^KEY_BITS-1; otherwise to NEXT.
REQ-022 SHALL perform key addition at KEY_BITS+1 bit width, so the overflow check does not wrap.
REQ-023 SHALL in NEXT update key to key+KEY_STEP and transition to INIT, giving a one-cycle bubble between candidates.
REQ-024 SHALL hold key stable from INIT entry to EVAL exit.
REQ-025 SHALL treat FOUND, EXHAUST and TIMEOUT as terminal: found, exhausted or timeout respectively =1, key frozen, return to IDLE only on reset.
REQ-026 SHALL drive busy=1 in every state except IDLE, FOUND, EXHAUST and TIMEOUT.
REQ-027 SHALL take the start-to-INIT transition on the clock edge after start=1 and drive mode from registered state, giving zero combinational paths from inputs to mode.

Reset
REQ-028 SHALL on reset assertion immediately force state=IDLE, mode=0, key=KEY_START, busy=0, found=0, exhausted=0, timeout=0, registered success=0 and watchdog=0.
REQ-029 SHALL on reset mid-phase deassert mode asynchronously, aborting the active sub-engine.

Configuration
REQ-030 SHALL include, when KEYSEQ_WATCHDOG_EN is defined, a phase counter cleared on every entry to INIT, SHUFFLE or DECRYPT and incremented each cycle in those states; reaching TIMEOUT_CYCLES without the matching finish bit SHALL transition to TIMEOUT.
REQ-031 SHALL, when KEYSEQ_WATCHDOG_EN is undefined, omit the counter, never enter TIMEOUT, and tie timeout to 0.

Structure
REQ-032 SHALL place the state enum, the mode encodings (MODE_IDLE, MODE_INIT, MODE_SHUFFLE, MODE_DECRYPT) and the finish_bus bit indices in shared package rc4_pkg, which the RAM controller also uses.
REQ-033 SHALL place the watchdog in sub-module phase_watchdog, instantiated only under KEYSEQ_WATCHDOG_EN.

Verification
REQ-034 SHALL cover happy path: start=1, finish pulses 0/1/2 with success=1 on first key -> mode sequence 001_000, 000_000, 010_000, 000_000, 011_000; found=1, key=0, busy=0.
REQ-035 SHALL cover iteration: success=0 for keys 0..4 and 1 for key 5 -> exactly 6 INIT entries, final key=24'h000005, found=1.
REQ-036 SHALL cover exhaustion: KEY_START=2^22-2, KEY_STEP=1, success always 0 -> two candidates tried, exhausted=1, key=24'h3FFFFF.
REQ-037 SHALL cover stray finish: finish_bus[2]=1 during INIT -> no state change, mode stays 001_000.
REQ-038 SHALL cover mid-phase reset: reset asserted in SHUFFLE -> mode=0 and key=KEY_START in the same cycle; restart with start=1 proceeds normally.
REQ-039 SHALL cover watchdog (KEYSEQ_WATCHDOG_EN defined, TIMEOUT_CYCLES=16): no finish in INIT -> timeout=1 after 16 cycles, mode=0.
